// File: rtl/mt_prng_stream_pkg.sv
// ---------------------------------------------------------------------------
// mt_pkg
// Shared definitions for the mt_prng_stream generator.
//   - FSM state encodings (SEED, RUN)
//   - MT19937 default constants (word size, depth, twist/tempering
//     parameters, seeding multiplier, power-on seed)
// No ports: package only.
// ---------------------------------------------------------------------------
package mt_pkg;

    // FSM state encodings
    localparam logic [0:0] SEED = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // MT19937 defaults
    localparam int          MT_W            = 32;
    localparam int          MT_N            = 624;
    localparam int          MT_M            = 397;
    localparam int          MT_R            = 31;
    localparam logic [31:0] MT_A            = 32'h9908B0DF;
    localparam int          MT_U            = 11;
    localparam int          MT_S            = 7;
    localparam logic [31:0] MT_B            = 32'h9D2C5680;
    localparam int          MT_T            = 15;
    localparam logic [31:0] MT_C            = 32'hEFC60000;
    localparam int          MT_L            = 18;
    localparam logic [31:0] MT_F            = 32'd1812433253;
    localparam logic [31:0] MT_DEFAULT_SEED = 32'd5489;

endpackage

// File: rtl/mt_prng_stream_if.sv
// ---------------------------------------------------------------------------
// mt_prng_stream_if
// Output stream bundle of the random word generator.
//   busy      generator is (re)seeding its state array
//   rv_valid  rv holds an unconsumed word
//   rv_ready  consumer accepts rv this cycle
//   rv        tempered random word
// Modports: master (generator side), slave (consumer side).
// ---------------------------------------------------------------------------
interface mt_prng_stream_if
    import mt_pkg::*;
#(
    parameter int W = MT_W
);

    logic         busy;
    logic         rv_valid;
    logic         rv_ready;
    logic [W-1:0] rv;

    modport master (
        output busy,
        output rv_valid,
        output rv,
        input  rv_ready
    );

    modport slave (
        input  busy,
        input  rv_valid,
        input  rv,
        output rv_ready
    );

endinterface

// File: rtl/mt_prng_stream_temper.sv
// ---------------------------------------------------------------------------
// mt_temper
// Combinational Mersenne-twister tempering of one state word.
//   x_in   raw twisted word
//   x_out  tempered output word
// ---------------------------------------------------------------------------
module mt_temper
    import mt_pkg::*;
#(
    parameter int           W = MT_W,
    parameter int           U = MT_U,
    parameter int           S = MT_S,
    parameter logic [W-1:0] B = W'(MT_B),
    parameter int           T = MT_T,
    parameter logic [W-1:0] C = W'(MT_C),
    parameter int           L = MT_L
) (
    input  logic [W-1:0] x_in,
    output logic [W-1:0] x_out
);

    logic [W-1:0] t1;
    logic [W-1:0] t2;
    logic [W-1:0] t3;

    always_comb begin
        t1    = x_in ^ (x_in >> U);
        t2    = t1 ^ ((t1 << S) & B);
        t3    = t2 ^ ((t2 << T) & C);
        x_out = t3 ^ (t3 >> L);
    end

endmodule

// File: rtl/mt_prng_stream.sv
// ---------------------------------------------------------------------------
// mt_prng_stream
// Mersenne-twister random word generator (MT19937 with default parameters).
// Seeds its state array one word per cycle, then twists one word per
// generated output over a circular array and streams tempered words.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   seed_load  one-cycle reseed request        (only with MT_RESEED_EN)
//   seed_val   seed sampled with seed_load      (only with MT_RESEED_EN)
//   rv_if      mt_prng_stream_if.master: busy, rv_valid, rv_ready, rv
//
// Build option: define MT_RESEED_EN to add runtime reseeding ports.
// ---------------------------------------------------------------------------
module mt_prng_stream
    import mt_pkg::*;
#(
    parameter int           W            = MT_W,
    parameter int           N            = MT_N,
    parameter int           M            = MT_M,
    parameter logic [W-1:0] A            = W'(MT_A),
    parameter int           R            = MT_R,
    parameter int           U            = MT_U,
    parameter int           S            = MT_S,
    parameter logic [W-1:0] B            = W'(MT_B),
    parameter int           T            = MT_T,
    parameter logic [W-1:0] C            = W'(MT_C),
    parameter int           L            = MT_L,
    parameter logic [W-1:0] F            = W'(MT_F),
    parameter logic [W-1:0] DEFAULT_SEED = W'(MT_DEFAULT_SEED)
) (
    input  logic          clk,
    input  logic          n_rst,
`ifdef MT_RESEED_EN
    input  logic          seed_load,
    input  logic [W-1:0]  seed_val,
`endif
    mt_prng_stream_if.master rv_if
);

    generate
        if (N < 2 || M <= 0 || M >= N || R <= 0 || R >= W) begin : g_bad_params
            $error("mt_prng_stream: illegal parameters (need N>=2, 0<M<N, 0<R<W)");
        end
    endgenerate

    localparam int           IW         = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [IW:0]  M_EXT      = (IW + 1)'(M);
    localparam logic [IW:0]  N_EXT      = (IW + 1)'(N);
    localparam logic [W-1:0] LOWER_MASK = {{(W - R){1'b0}}, {R{1'b1}}};
    localparam logic [W-1:0] UPPER_MASK = ~LOWER_MASK;

    logic [0:0]    state;
    logic          busy;
    logic          rv_valid;
    logic [W-1:0]  rv;
    logic [IW-1:0] k;
    logic [IW-1:0] i;
    logic [W-1:0]  seed_reg;
    logic [W-1:0]  prev_word;
    logic [W-1:0]  mt [N];

    logic          reseed_req;
    logic [W-1:0]  reseed_val;
    logic [IW-1:0] i_next;
    logic [IW-1:0] i_mid;
    logic [IW:0]   mid_sum;
    logic [W-1:0]  y;
    logic [W-1:0]  twisted;
    logic [W-1:0]  tempered;
    logic [W-1:0]  seed_word;
    logic          gen;
    logic          mt_we;
    logic [IW-1:0] mt_waddr;
    logic [W-1:0]  mt_wdata;

`ifdef MT_RESEED_EN
    assign reseed_req = seed_load;
    assign reseed_val = seed_val;
`else
    assign reseed_req = 1'b0;
    assign reseed_val = DEFAULT_SEED;
`endif

    assign rv_if.busy     = busy;
    assign rv_if.rv_valid = rv_valid;
    assign rv_if.rv       = rv;

    // Circular indices i+1 and i+M, wrapped by compare-and-subtract.
    always_comb begin
        i_next  = (i == LAST_IDX) ? '0 : i + 1'b1;
        mid_sum = {1'b0, i} + M_EXT;
        i_mid   = (mid_sum >= N_EXT) ? IW'(mid_sum - N_EXT) : mid_sum[IW-1:0];
    end

    // Incremental twist of word i. Reads see pre-write contents, so wrapped
    // indices pick up already-twisted words exactly like the block twist.
    always_comb begin
        y       = (mt[i] & UPPER_MASK) | (mt[i_next] & LOWER_MASK);
        twisted = mt[i_mid] ^ (y >> 1) ^ (y[0] ? A : '0);
    end

    // Seeding recurrence; the previous word is kept in a register so the
    // array needs no extra read port during SEED.
    always_comb begin
        seed_word = (k == '0) ? seed_reg
                              : (F * (prev_word ^ (prev_word >> (W - 2)))) + W'(k);
    end

    assign gen = (state == RUN) && (!rv_valid || rv_if.rv_ready);

    mt_temper #(
        .W(W), .U(U), .S(S), .B(B), .T(T), .C(C), .L(L)
    ) u_temper (
        .x_in  (twisted),
        .x_out (tempered)
    );

    // Single write port shared by seeding and twisting; a reseed request
    // suppresses this cycle's write.
    always_comb begin
        mt_we    = 1'b0;
        mt_waddr = i;
        mt_wdata = twisted;
        if (!reseed_req) begin
            if (state == SEED && busy) begin
                mt_we    = 1'b1;
                mt_waddr = k;
                mt_wdata = seed_word;
            end else if (gen) begin
                mt_we = 1'b1;
            end
        end
    end

    // State array storage, cleared by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int j = 0; j < N; j++) begin
                mt[j] <= '0;
            end
        end else if (mt_we) begin
            mt[mt_waddr] <= mt_wdata;
        end
    end

    // Control FSM. After reset the FSM sits in SEED with busy low; the first
    // edge latches DEFAULT_SEED and raises busy, behaving like an implicit
    // seed_load, so busy is high for exactly N cycles in both cases.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= SEED;
            busy      <= 1'b0;
            k         <= '0;
            i         <= '0;
            seed_reg  <= '0;
            prev_word <= '0;
            rv_valid  <= 1'b0;
            rv        <= '0;
        end else if (reseed_req) begin
            state    <= SEED;
            busy     <= 1'b1;
            k        <= '0;
            seed_reg <= reseed_val;
            rv_valid <= 1'b0;
        end else if (state == SEED) begin
            if (!busy) begin
                busy     <= 1'b1;
                k        <= '0;
                seed_reg <= DEFAULT_SEED;
            end else begin
                prev_word <= seed_word;
                if (k == LAST_IDX) begin
                    state <= RUN;
                    busy  <= 1'b0;
                    i     <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end else if (gen) begin
            i        <= i_next;
            rv       <= tempered;
            rv_valid <= 1'b1;
        end
    end

endmodule
